// File: rtl/whackamole_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
// Holds the round states, the hole numbering used by vga_display and the LFSR seed.
package whackamole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_UP   = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    localparam int NUM_HOLES = 5;

    localparam logic [2:0] HOLE_TOP   = 3'd0;
    localparam logic [2:0] HOLE_LEFT  = 3'd1;
    localparam logic [2:0] HOLE_CTR   = 3'd2;
    localparam logic [2:0] HOLE_RIGHT = 3'd3;
    localparam logic [2:0] HOLE_BOT   = 3'd4;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Next hole in display order, wrapping bottom back to top.
    function automatic logic [2:0] next_hole(input logic [2:0] p);
        case (p)
            HOLE_TOP:   next_hole = HOLE_LEFT;
            HOLE_LEFT:  next_hole = HOLE_CTR;
            HOLE_CTR:   next_hole = HOLE_RIGHT;
            HOLE_RIGHT: next_hole = HOLE_BOT;
            default:    next_hole = HOLE_TOP;
        endcase
    endfunction

endpackage

// File: rtl/whackamole_game_ctrl_if.sv
// Button-side inputs and display-side outputs of the game sequencer.
// master = button/display side, slave = whackamole_game_ctrl.
interface whackamole_game_ctrl_if;
    logic       start;
    logic       btn_valid;
    logic [2:0] btn_pos;
    logic [2:0] mole_position;
    logic       mole_up;
    logic       guess_correct;
    logic       guess_wrong;
    logic       game_over;
    logic [3:0] digit_1;
    logic [3:0] digit_2;
    logic [2:0] lives;

    modport master (
        output start, btn_valid, btn_pos,
        input  mole_position, mole_up, guess_correct, guess_wrong,
        input  game_over, digit_1, digit_2, lives
    );

    modport slave (
        input  start, btn_valid, btn_pos,
        output mole_position, mole_up, guess_correct, guess_wrong,
        output game_over, digit_1, digit_2, lives
    );
endinterface

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) reduced mod 5 to a hole index.
// Latency: pos_rand follows the registered LFSR state; no backpressure, steps every cycle.
module mole_lfsr
    import whackamole_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] pos_rand
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pos_rand = 3'(lfsr_q % 8'(NUM_HOLES));

endmodule

// File: rtl/whackamole_game_ctrl.sv
// Round sequencer: mole timing, hit judging, BCD score and lives for vga_display.
// Latency: a press sampled at edge N is reflected on all outputs after edge N; no backpressure.
module whackamole_game_ctrl
    import whackamole_pkg::*;
#(
    parameter int MOLE_TICKS = 50_000_000,
    parameter int GAP_TICKS  = 10_000_000,
    parameter int MIN_TICKS  = 15_000_000,
    parameter int SPEED_STEP = 2_500_000,
    parameter int LIVES      = 3
) (
    input logic                  clk,
    input logic                  rst,
    whackamole_game_ctrl_if.slave gif
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_GAP  = ST_GAP;
    localparam logic [1:0] S_UP   = ST_UP;
    localparam logic [1:0] S_OVER = ST_OVER;

    localparam logic [27:0] MOLE_T = 28'(MOLE_TICKS);
    localparam logic [27:0] GAP_T  = 28'(GAP_TICKS);
    localparam logic [27:0] MIN_T  = 28'(MIN_TICKS);
    localparam logic [27:0] STEP_T = 28'(SPEED_STEP);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

    logic [1:0]  state_q, state_d;
    logic [27:0] cnt_q, cnt_d;
    logic [27:0] cur_ticks_q, cur_ticks_d;
    logic [2:0]  pos_q, pos_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [2:0]  lives_q, lives_d;
    logic        correct_q, correct_d;
    logic        wrong_q, wrong_d;
    logic        mole_up_q, mole_up_d;
    logic        over_q, over_d;
    logic [2:0]  pos_rand;

    mole_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .pos_rand (pos_rand)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_ticks_d = cur_ticks_q;
        pos_d       = pos_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        lives_d     = lives_q;
        correct_d   = 1'b0;
        wrong_d     = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (gif.start) begin
                    tens_d      = 4'd0;
                    ones_d      = 4'd0;
                    lives_d     = LIVES_INIT;
                    cur_ticks_d = MOLE_T;
                    cnt_d       = 28'd0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_T - 28'd1) begin
                    pos_d   = (pos_rand == pos_q) ? next_hole(pos_rand) : pos_rand;
                    cnt_d   = 28'd0;
                    state_d = S_UP;
                end else begin
                    cnt_d = cnt_q + 28'd1;
                end
            end
            S_UP: begin
                // A press always wins over a timeout landing on the same cycle.
                if (gif.btn_valid && (gif.btn_pos == pos_q)) begin
                    correct_d = 1'b1;
                    if (!((tens_q == 4'd9) && (ones_q == 4'd9))) begin
                        if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = tens_q + 4'd1;
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end
                    cur_ticks_d = (cur_ticks_q >= MIN_T + STEP_T) ? cur_ticks_q - STEP_T : MIN_T;
                    cnt_d       = 28'd0;
                    state_d     = S_GAP;
                end else if (gif.btn_valid || (cnt_q == cur_ticks_q - 28'd1)) begin
                    wrong_d = 1'b1;
                    lives_d = lives_q - 3'd1;
                    cnt_d   = 28'd0;
                    state_d = (lives_q == 3'd1) ? S_OVER : S_GAP;
                end else begin
                    cnt_d = cnt_q + 28'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mole_up_d = (state_d == S_UP);
        over_d    = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 28'd0;
            cur_ticks_q <= MOLE_T;
            pos_q       <= HOLE_TOP;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            lives_q     <= 3'd0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            mole_up_q   <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_ticks_q <= cur_ticks_d;
            pos_q       <= pos_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            lives_q     <= lives_d;
            correct_q   <= correct_d;
            wrong_q     <= wrong_d;
            mole_up_q   <= mole_up_d;
            over_q      <= over_d;
        end
    end

    assign gif.mole_position = pos_q;
    assign gif.mole_up       = mole_up_q;
    assign gif.guess_correct = correct_q;
    assign gif.guess_wrong   = wrong_q;
    assign gif.game_over     = over_q;
    assign gif.digit_1       = tens_q;
    assign gif.digit_2       = ones_q;
    assign gif.lives         = lives_q;

endmodule
